// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Decides when EX-stage forwarding cannot supply an operand, so the pipeline
//   has to stall instead. It keeps a private scoreboard of the instructions in
//   EX and MEM, and drives these outputs:
//     - PC and IF/ID write enables
//     - the ID/EX bubble
//     - the IF/ID flush
//     - a whole-pipe freeze while data memory is slow
//   It also keeps stall statistics.
// Ports
//   clk_i, rst_i                clock, async active-high reset
//   ID_*_i                      decoded fields of the instruction in ID
//   ID_Flush_i                  taken branch in ID (discard IF instruction)
//   DMem_Ready_i                MEM-stage data access completes this cycle
//   PC_Write_o, IFID_Write_o    front-end enables
//   IFID_Flush_o                IF/ID loads a NOP
//   IDEX_Bubble_o               ID/EX loads a NOP
//   Pipe_Freeze_o               every pipeline register holds
//   LoadUse_Cnt_o               saturating count of load-use stall cycles
//   MemWait_Cnt_o               saturating count of memory-freeze cycles
//   Mem_Timeout_o               sticky flag: a memory wait reached MEM_TIMEOUT cycles
module hazard_stall_unit #(
    parameter int ADDR_W      = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ID_Valid_i,
    input  logic [ADDR_W-1:0] ID_RsAddr_i,
    input  logic [ADDR_W-1:0] ID_RtAddr_i,
    input  logic              ID_UseRs_i,
    input  logic              ID_UseRt_i,
    input  logic [ADDR_W-1:0] ID_WriteAddr_i,
    input  logic              ID_RegWrite_i,
    input  logic              ID_MemRead_i,
    input  logic              ID_MemWrite_i,
    input  logic              ID_Flush_i,
    input  logic              DMem_Ready_i,
    output logic              PC_Write_o,
    output logic              IFID_Write_o,
    output logic              IFID_Flush_o,
    output logic              IDEX_Bubble_o,
    output logic              Pipe_Freeze_o,
    output logic [CNT_W-1:0]  LoadUse_Cnt_o,
    output logic [CNT_W-1:0]  MemWait_Cnt_o,
    output logic              Mem_Timeout_o
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    // Scoreboard: EX slot and MEM slot
    logic              ex_v_q, ex_rw_q, ex_mr_q, ex_mw_q;
    logic [ADDR_W-1:0] ex_wa_q;
    logic              mem_v_q, mem_rw_q, mem_memop_q;
    logic [ADDR_W-1:0] mem_wa_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d, mw_cnt_q, mw_cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              tmo_q, tmo_d;

    logic lu, mwait;

    // Only a load in EX can create a hazard. Its data is not ready until the
    // end of MEM, so forwarding covers every other producer. x0 is excluded.
    assign lu = ex_v_q & ex_mr_q & (ex_wa_q != '0) & ID_Valid_i &
                ((ID_UseRs_i & (ID_RsAddr_i == ex_wa_q)) |
                 (ID_UseRt_i & (ID_RtAddr_i == ex_wa_q)));
    assign mwait = mem_v_q & mem_memop_q & ~DMem_Ready_i;

    // Priority: freeze > load-use > flush. A flush is dropped during a load-use
    // stall because the branch stays in ID and presents itself again.
    always_comb begin
        Pipe_Freeze_o = mwait;
        PC_Write_o    = ~mwait & ~lu;
        IFID_Write_o  = ~mwait & ~lu;
        IDEX_Bubble_o = ~mwait & lu;
        IFID_Flush_o  = ~mwait & ~lu & ID_Flush_i & ID_Valid_i;
    end

    always_comb begin
        state_d  = mwait ? MEM_WAIT : (lu ? LU_STALL : RUN);
        lu_cnt_d = lu_cnt_q;
        mw_cnt_d = mw_cnt_q;
        wait_d   = '0;
        if (state_d == LU_STALL && lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + CNT_W'(1);
        if (state_d == MEM_WAIT && mw_cnt_q != '1) mw_cnt_d = mw_cnt_q + CNT_W'(1);
        // The wait counter saturates at the limit. The sticky flag latches on
        // the edge where the counter reaches the limit.
        if (mwait) wait_d = (wait_q == WAIT_W'(MEM_TIMEOUT)) ? wait_q : wait_q + WAIT_W'(1);
        tmo_d = tmo_q | (wait_d == WAIT_W'(MEM_TIMEOUT));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_v_q      <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_mw_q     <= 1'b0;
            ex_wa_q     <= '0;
            mem_v_q     <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_memop_q <= 1'b0;
            mem_wa_q    <= '0;
        end else if (!mwait) begin
            mem_v_q     <= ex_v_q;
            mem_rw_q    <= ex_rw_q;
            mem_memop_q <= ex_mr_q | ex_mw_q;
            mem_wa_q    <= ex_wa_q;
            if (lu || !ID_Valid_i) begin
                ex_v_q  <= 1'b0;
                ex_rw_q <= 1'b0;
                ex_mr_q <= 1'b0;
                ex_mw_q <= 1'b0;
                ex_wa_q <= '0;
            end else begin
                ex_v_q  <= 1'b1;
                ex_rw_q <= ID_RegWrite_i;
                ex_mr_q <= ID_MemRead_i;
                ex_mw_q <= ID_MemWrite_i;
                ex_wa_q <= ID_WriteAddr_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            lu_cnt_q <= '0;
            mw_cnt_q <= '0;
            wait_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            mw_cnt_q <= mw_cnt_d;
            wait_q   <= wait_d;
            tmo_q    <= tmo_d;
        end
    end

    assign LoadUse_Cnt_o = lu_cnt_q;
    assign MemWait_Cnt_o = mw_cnt_q;
    assign Mem_Timeout_o = tmo_q;

    // Some fields are tracked only so the scoreboard fully mirrors EX and MEM,
    // and the registered state is kept only for reporting. None of these
    // drive an output.
    logic unused_sb;
    assign unused_sb = ^{mem_rw_q, mem_wa_q, state_q};
endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
    logic       clk_i = 1'b0, rst_i = 1'b1;
    logic       ID_Valid_i, ID_UseRs_i, ID_UseRt_i, ID_RegWrite_i;
    logic       ID_MemRead_i, ID_MemWrite_i, ID_Flush_i, DMem_Ready_i;
    logic [4:0] ID_RsAddr_i, ID_RtAddr_i, ID_WriteAddr_i;
    logic       PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Pipe_Freeze_o, Mem_Timeout_o;
    logic [15:0] LoadUse_Cnt_o, MemWait_Cnt_o;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit #(.ADDR_W(5), .CNT_W(16), .MEM_TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_Valid_i(ID_Valid_i), .ID_RsAddr_i(ID_RsAddr_i), .ID_RtAddr_i(ID_RtAddr_i),
        .ID_UseRs_i(ID_UseRs_i), .ID_UseRt_i(ID_UseRt_i), .ID_WriteAddr_i(ID_WriteAddr_i),
        .ID_RegWrite_i(ID_RegWrite_i), .ID_MemRead_i(ID_MemRead_i), .ID_MemWrite_i(ID_MemWrite_i),
        .ID_Flush_i(ID_Flush_i), .DMem_Ready_i(DMem_Ready_i),
        .PC_Write_o(PC_Write_o), .IFID_Write_o(IFID_Write_o), .IFID_Flush_o(IFID_Flush_o),
        .IDEX_Bubble_o(IDEX_Bubble_o), .Pipe_Freeze_o(Pipe_Freeze_o),
        .LoadUse_Cnt_o(LoadUse_Cnt_o), .MemWait_Cnt_o(MemWait_Cnt_o), .Mem_Timeout_o(Mem_Timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control vector {freeze, pc_write, ifid_write, bubble, flush}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, Pipe_Freeze_o, PC_Write_o, IFID_Write_o, IDEX_Bubble_o, IFID_Flush_o},
            {27'd0, exp});
    endtask

    task automatic idin(input logic v, input logic [4:0] rs, input logic ur,
                        input logic [4:0] rt, input logic ut, input logic [4:0] wa,
                        input logic rw, input logic mr, input logic mw, input logic fl);
        ID_Valid_i = v; ID_RsAddr_i = rs; ID_UseRs_i = ur; ID_RtAddr_i = rt; ID_UseRt_i = ut;
        ID_WriteAddr_i = wa; ID_RegWrite_i = rw; ID_MemRead_i = mr; ID_MemWrite_i = mw;
        ID_Flush_i = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [4:0] RUNV   = 5'b01100;
    localparam logic [4:0] LUV    = 5'b00010;
    localparam logic [4:0] FRZV   = 5'b10000;
    localparam logic [4:0] FLUSHV = 5'b01101;

    initial begin
        DMem_Ready_i = 1'b1;
        idin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #11;
        chk_ctl("reset_ctl", RUNV);
        chk("reset_lucnt", LoadUse_Cnt_o, 0);
        chk("reset_mwcnt", MemWait_Cnt_o, 0);
        chk("reset_tmo", Mem_Timeout_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // 1: lw $2 then dependent add
        idin(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        chk_ctl("lw_issue", RUNV);
        tick();
        idin(1, 2, 1, 3, 1, 4, 1, 0, 0, 0);
        chk_ctl("lu_stall", LUV);
        tick();
        chk_ctl("lu_after", RUNV);
        chk("lu_cnt1", LoadUse_Cnt_o, 1);
        tick();                                   // EX=add $4

        // 2: lw $0 -> no hazard; ALU producer -> no hazard
        idin(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);       // lw $0
        tick();
        idin(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);       // add $2 reading $0
        chk_ctl("x0_nostall", RUNV);
        tick();
        idin(1, 2, 1, 2, 1, 5, 1, 1, 0, 0);       // lw $5 reading $2 (ALU producer)
        chk_ctl("alu_nostall", RUNV);
        chk("lu_cnt_still1", LoadUse_Cnt_o, 1);
        tick();                                   // EX=lw5, MEM=add2
        idin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();                                   // MEM=lw5

        // 3: three-cycle memory wait
        DMem_Ready_i = 1'b0; #1;
        chk_ctl("frz_c1", FRZV);
        tick();
        chk_ctl("frz_c2", FRZV);
        tick();
        chk_ctl("frz_c3", FRZV);
        tick();
        chk("mw_cnt3", MemWait_Cnt_o, 3);
        chk_ctl("frz_held", FRZV);                // load still in MEM
        DMem_Ready_i = 1'b1; #1;
        chk_ctl("frz_release", RUNV);

        // 4: freeze and load-use together
        idin(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);       // lw $7
        tick();
        idin(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);       // lw $6
        tick();                                   // EX=lw6, MEM=lw7
        idin(1, 1, 1, 6, 1, 9, 1, 0, 0, 0);       // add uses rt=$6
        DMem_Ready_i = 1'b0; #1;
        chk_ctl("frz_over_lu", FRZV);
        tick();
        chk("lu_cnt_frozen", LoadUse_Cnt_o, 1);
        chk("mw_cnt4", MemWait_Cnt_o, 4);
        DMem_Ready_i = 1'b1; #1;
        chk_ctl("lu_after_frz", LUV);
        tick();
        chk("lu_cnt2", LoadUse_Cnt_o, 2);

        // 6: flush
        idin(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_ctl("flush_nohaz", FLUSHV);
        idin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_ctl("flush_invalid", RUNV);
        idin(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);       // lw $8
        tick();
        idin(1, 8, 1, 0, 0, 0, 0, 0, 0, 1);       // branch on $8
        chk_ctl("flush_lu", LUV);
        tick();                                   // MEM=lw8, EX empty
        chk("lu_cnt3", LoadUse_Cnt_o, 3);

        // 5: timeout at 8 wait cycles
        idin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DMem_Ready_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_before", Mem_Timeout_o, 0);
        tick();
        chk("tmo_set", Mem_Timeout_o, 1);
        chk_ctl("tmo_still_frz", FRZV);
        DMem_Ready_i = 1'b1;
        tick();
        chk("tmo_sticky", Mem_Timeout_o, 1);
        chk("mw_cnt12", MemWait_Cnt_o, 12);
        idin(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);       // lw $9
        tick();
        idin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();                                   // MEM=lw9
        DMem_Ready_i = 1'b0;
        tick();
        chk_ctl("frz_pre_rst", FRZV);
        #2 rst_i = 1'b1;
        #1;
        chk_ctl("rst_mid_ctl", RUNV);
        chk("rst_mid_lucnt", LoadUse_Cnt_o, 0);
        chk("rst_mid_mwcnt", MemWait_Cnt_o, 0);
        chk("rst_mid_tmo", Mem_Timeout_o, 0);
        @(negedge clk_i); rst_i = 1'b0;
        tick();
        chk_ctl("rst_sb_empty", RUNV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
